// File: rtl/video_pkg.sv
// Shared video constants: default 720p timing, pattern mode codes, FSM states.
package video_pkg;

  // Default 1280x720 frame timing
  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_H_FP     = 48;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BP     = 240;
  localparam int DEF_V_ACTIVE = 720;
  localparam int DEF_V_FP     = 3;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 22;

  // Counter width; wide enough for any sane timing and for the checker bit index (up to 9)
  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    PAT_BARS  = 3'd0,
    PAT_HRAMP = 3'd1,
    PAT_VRAMP = 3'd2,
    PAT_CHECK = 3'd3,
    PAT_GRID  = 3'd4,
    PAT_SOLID = 3'd5
  } pat_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical raster counters with active/sync decode.
// Counters advance while run=1 and are held at zero otherwise.
module video_timing_cnt
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             dv,
  output logic             hs,
  output logic             vs,
  output logic             h_last,
  output logic             frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  // Raster scan: h wraps every line, v steps on each h wrap and wraps at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign h          = h_cnt;
  assign v          = v_cnt;
  assign h_last     = (h_cnt == H_MAX);
  assign frame_last = (h_cnt == H_MAX) && (v_cnt == V_MAX);
  assign dv         = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign hs         = (h_cnt >= HS_START) && (h_cnt < HS_END);
  // vs depends on v only, so its edges land where v changes, i.e. at h=0
  assign vs         = (v_cnt >= VS_START) && (v_cnt < VS_END);

endmodule

// File: rtl/video_pattern_gen.sv
// Synthetic RGB video source: run/drain FSM, per-frame pattern select, registered outputs.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sw,
  output logic [7:0] tx_red,
  output logic [7:0] tx_green,
  output logic [7:0] tx_blue,
  output logic       tx_dv,
  output logic       tx_hs,
  output logic       tx_vs,
  output logic       frame_start,
  output logic       busy
);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);
  localparam int   BAR_W = H_ACTIVE / 8;

  state_t           state, state_next;
  logic             running;
  logic [CNT_W-1:0] h, v;
  logic             dv, hs, vs, h_last, frame_last;
  logic             frame_first;
  logic [2:0]       mode_reg, mode_cur;
  logic [4:0]       arg_reg, arg_cur;
  logic [CNT_W-1:0] bar_px;
  logic [2:0]       bar_idx;
  logic [3:0]       chk_bit;
  logic [23:0]      rgb;

  assign running = (state != ST_IDLE);
  assign busy    = running;

  video_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .run       (running),
    .h         (h),
    .v         (v),
    .dv        (dv),
    .hs        (hs),
    .vs        (vs),
    .h_last    (h_last),
    .frame_last(frame_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state: stopping is deferred to the last pixel so only whole frames leave the block
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (en) state_next = ST_RUN;
      ST_RUN:   if (!en) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (en)              state_next = ST_RUN;
        else if (frame_last) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // The first pixel of a frame already uses the fresh switch value; the rest use the latched one
  assign frame_first = running && (h == '0) && (v == '0);
  assign mode_cur    = frame_first ? sw[2:0] : mode_reg;
  assign arg_cur     = frame_first ? sw[7:3] : arg_reg;

  // Latch pattern selection once per frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg <= '0;
      arg_reg  <= '0;
    end else if (frame_first) begin
      mode_reg <= sw[2:0];
      arg_reg  <= sw[7:3];
    end
  end

  // Colour-bar position tracked alongside h so no divider is needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (!running || h_last) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == CNT_W'(BAR_W - 1)) begin
      bar_px <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px <= bar_px + CNT_W'(1);
    end
  end

  assign chk_bit = {1'b0, arg_cur[2:0]} + 4'd2;

  // Pattern colour for the current counter position
  always_comb begin
    rgb = '0;
    case (mode_cur)
      // bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0]
      PAT_BARS:  rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      PAT_HRAMP: rgb = {3{h[7:0]}};
      PAT_VRAMP: rgb = {3{v[7:0]}};
      PAT_CHECK: rgb = {24{h[chk_bit] ^ v[chk_bit]}};
      PAT_GRID:  rgb = {24{(h[4:0] == 5'd0) && (v[4:0] == 5'd0)}};
      PAT_SOLID: rgb = {3{arg_cur, 3'b000}};
      default:   rgb = '0;
    endcase
  end

  // Output stage: one cycle behind the counters, blanked and sync-idle when not running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {tx_red, tx_green, tx_blue} <= '0;
      tx_dv       <= 1'b0;
      tx_hs       <= ~HS_ON;
      tx_vs       <= ~VS_ON;
      frame_start <= 1'b0;
    end else if (running) begin
      {tx_red, tx_green, tx_blue} <= dv ? rgb : 24'h0;
      tx_dv       <= dv;
      tx_hs       <= hs ? HS_ON : ~HS_ON;
      tx_vs       <= vs ? VS_ON : ~VS_ON;
      frame_start <= dv && (h == '0) && (v == '0);
    end else begin
      {tx_red, tx_green, tx_blue} <= '0;
      tx_dv       <= 1'b0;
      tx_hs       <= ~HS_ON;
      tx_vs       <= ~VS_ON;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench: directed 720p checks on one instance, randomized model-checked run on a small-raster instance.
module tb_video_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small raster for the randomized instance (hsync active-low to exercise polarity)
  localparam int BH_A = 64, BH_FP = 4, BH_S = 4, BH_BP = 8;
  localparam int BV_A = 40, BV_FP = 2, BV_S = 2, BV_BP = 4;
  localparam int BHT = BH_A + BH_FP + BH_S + BH_BP;
  localparam int BVT = BV_A + BV_FP + BV_S + BV_BP;
  localparam int BFT = BHT * BVT;

  logic       a_rst = 1'b0, a_en = 1'b0;
  logic [7:0] a_sw = 8'h00;
  logic [7:0] a_r, a_g, a_b;
  logic       a_dv, a_hs, a_vs, a_fs, a_busy;

  logic       b_rst = 1'b0, b_en = 1'b0;
  logic [7:0] b_sw = 8'h00;
  logic [7:0] b_r, b_g, b_b;
  logic       b_dv, b_hs, b_vs, b_fs, b_busy;

  video_pattern_gen u_dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .sw(a_sw),
    .tx_red(a_r), .tx_green(a_g), .tx_blue(a_b),
    .tx_dv(a_dv), .tx_hs(a_hs), .tx_vs(a_vs), .frame_start(a_fs), .busy(a_busy)
  );

  video_pattern_gen #(
    .H_ACTIVE(BH_A), .H_FP(BH_FP), .H_SYNC(BH_S), .H_BP(BH_BP),
    .V_ACTIVE(BV_A), .V_FP(BV_FP), .V_SYNC(BV_S), .V_BP(BV_BP),
    .HS_POL(0), .VS_POL(1)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .sw(b_sw),
    .tx_red(b_r), .tx_green(b_g), .tx_blue(b_b),
    .tx_dv(b_dv), .tx_hs(b_hs), .tx_vs(b_vs), .frame_start(b_fs), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Packed view {rgb, dv, hs, vs, frame_start, busy}
  function automatic logic [31:0] vec_a();
    return {3'b0, a_r, a_g, a_b, a_dv, a_hs, a_vs, a_fs, a_busy};
  endfunction

  function automatic logic [31:0] vec_b();
    return {3'b0, b_r, b_g, b_b, b_dv, b_hs, b_vs, b_fs, b_busy};
  endfunction

  // ---------------- reference model for instance B ----------------
  // Frame position is a single pixel index p; h/v derived by division.
  bit          m_busy, m_drain;
  int          m_p;
  logic [2:0]  m_mode;
  logic [4:0]  m_arg;
  logic [31:0] m_exp;
  logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic [23:0] pix(input int h, input int v, input logic [2:0] mode,
                                      input logic [4:0] arg);
    logic [7:0] g;
    int k;
    case (mode)
      3'd0: return bar_col[h / (BH_A / 8)];
      3'd1: begin g = 8'(h % 256); return {g, g, g}; end
      3'd2: begin g = 8'(v % 256); return {g, g, g}; end
      3'd3: begin
        k = int'(arg[2:0]) + 2;
        return ((((h >> k) ^ (v >> k)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      end
      3'd4: return ((h % 32 == 0) && (v % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
      3'd5: begin g = {arg, 3'b000}; return {g, g, g}; end
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_drain = 0;
    m_p     = 0;
    m_exp   = {3'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic model_step(input logic en, input logic [7:0] sw);
    int h, v;
    logic dv, hs, vs, fs;
    logic [23:0] c;
    if (!m_busy) begin
      m_busy  = en;
      m_drain = 0;
      m_p     = 0;
      m_exp   = {3'b0, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0, m_busy};
    end else begin
      h = m_p % BHT;
      v = m_p / BHT;
      if (m_p == 0) begin
        m_mode = sw[2:0];
        m_arg  = sw[7:3];
      end
      dv = (h < BH_A) && (v < BV_A);
      hs = !((h >= BH_A + BH_FP) && (h < BH_A + BH_FP + BH_S));
      vs = (v >= BV_A + BV_FP) && (v < BV_A + BV_FP + BV_S);
      fs = (m_p == 0);
      c  = dv ? pix(h, v, m_mode, m_arg) : 24'h0;
      if (en)                          m_drain = 0;
      else if (m_drain && m_p == BFT-1) m_busy = 0;
      else                             m_drain = 1;
      m_p   = (m_p == BFT - 1) ? 0 : m_p + 1;
      m_exp = {3'b0, c, dv, hs, vs, fs, m_busy};
    end
  endtask

  // One clock of instance B; entered and left at a negedge
  task automatic b_cycle(input logic en, input logic [7:0] sw);
    b_en = en;
    b_sw = sw;
    @(posedge clk);
    model_step(en, sw);
    @(negedge clk);
    check("b_pix", vec_b(), m_exp);
  endtask

  // Asynchronous reset mid-cycle, held across one clock edge
  task automatic b_reset_mid();
    #2 b_rst = 1'b0;
    #1 model_reset();
    check("b_rst_async", vec_b(), m_exp);
    @(negedge clk);
    check("b_rst_hold", vec_b(), m_exp);
    b_rst = 1'b1;
  endtask

  initial begin
    logic [7:0] sw_cur;
    logic       en_cur;
    int n, chg, evt;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("a_reset", vec_a(), 32'h0);
    check("b_reset", vec_b(), m_exp);

    // ---- instance A: 720p colour bars ----
    a_rst = 1'b1;
    @(negedge clk);
    a_en = 1'b1;
    a_sw = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("a_lat1_dv", {31'b0, a_dv}, 32'h0);
    check("a_lat1_busy", {31'b0, a_busy}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("a_px0", vec_a(), {3'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int i = 1; i <= 1280; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1)    check("a_px1_fs", {31'b0, a_fs}, 32'h0);
      if (i == 159)  check("a_px159", {8'h0, a_r, a_g, a_b}, 32'h00FFFFFF);
      if (i == 160)  check("a_px160", {8'h0, a_r, a_g, a_b}, 32'h00FFFF00);
      if (i == 800)  check("a_px800", {8'h0, a_r, a_g, a_b}, 32'h00FF0000);
      if (i == 1279) check("a_px1279", vec_a(), {3'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      if (i == 1280) check("a_px1280_dv", {31'b0, a_dv}, 32'h0);
    end
    // mid-line reset on A: outputs go idle without waiting for a clock
    #2 a_rst = 1'b0;
    #1 check("a_rst_async", vec_a(), 32'h0);
    a_en = 1'b0;

    // ---- instance B: randomized segments against the model ----
    @(negedge clk);
    b_rst  = 1'b1;
    en_cur = 1'b1;
    for (int s = 0; s < 12; s++) begin
      sw_cur = {5'($urandom), 3'(s % 8)};
      n      = $urandom_range(1500, 4500);
      chg    = $urandom_range(0, n - 1);
      evt    = $urandom_range(0, n - 1);
      if (s % 4 != 2) en_cur = 1'b1;
      for (int c = 0; c < n; c++) begin
        if (c == chg) sw_cur = 8'($urandom);
        case (s % 4)
          1: if (c == evt) en_cur = 1'b0;
          2: if ($urandom_range(0, 199) == 0) en_cur = ~en_cur;
          default: en_cur = 1'b1;
        endcase
        if ((s % 4 == 3) && (c == evt)) b_reset_mid();
        else                            b_cycle(en_cur, sw_cur);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
